// File: rtl/w_seq_tx.sv
// Run-length transmitter for the detector's w line.
// Each command drives w high for LEN cycles and then low for at least GAP_MIN cycles.
module w_seq_tx #(
    parameter int CNT_W   = 8,
    parameter int GAP_MIN = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [CNT_W-1:0] req_len,
    input  logic [CNT_W-1:0] req_gap,
    input  logic             abort,
    output logic             w,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

    localparam logic [CNT_W-1:0] GAP_MIN_C = CNT_W'(GAP_MIN);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             w_q, w_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             last_gap;
    logic             accept;
    logic [CNT_W-1:0] g_eff;

    always_comb begin
        last_gap  = (state_q == GAP) && (cnt_q == ONE_C);
        req_ready = ((state_q == IDLE) || last_gap) && !abort;
        accept    = req_valid && req_ready;
        g_eff     = (req_gap < GAP_MIN_C) ? GAP_MIN_C : req_gap;

        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;

        case (state_q)
            IDLE, GAP: begin
                if (state_q == GAP && !last_gap) begin
                    cnt_d = cnt_q - ONE_C;
                end else if (accept) begin
                    // A new command in the last gap cycle chains with no idle bubble.
                    gap_d = g_eff;
                    if (req_len != '0) begin
                        state_d = HIGH;
                        cnt_d   = req_len;
                    end else begin
                        state_d = GAP;
                        cnt_d   = g_eff;
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            HIGH: begin
                if (abort) begin
                    state_d = GAP;
                    cnt_d   = GAP_MIN_C;
                end else if (cnt_q == ONE_C) begin
                    state_d = GAP;
                    cnt_d   = gap_q;
                end else begin
                    cnt_d = cnt_q - ONE_C;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            gap_d   = '0;
        end

        // Outputs are decoded from the next state so they leave the flops glitch-free.
        w_d    = (state_d == HIGH);
        busy_d = (state_d != IDLE);
        done_d = (state_d == GAP) && (cnt_d == ONE_C);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            w_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            w_q     <= w_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign w    = w_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_w_seq_tx.sv
// Bench for w_seq_tx: directed steps then random traffic, checked against a
// per-cycle schedule model that expands each accepted command into its output samples.
module tb_w_seq_tx;

    localparam int CNT_W   = 8;
    localparam int GAP_MIN = 1;

    logic             clk = 1'b0;
    logic             clr;
    logic             req_valid;
    logic             req_ready;
    logic [CNT_W-1:0] req_len;
    logic [CNT_W-1:0] req_gap;
    logic             abort;
    logic             w;
    logic             busy;
    logic             done;

    w_seq_tx #(.CNT_W(CNT_W), .GAP_MIN(GAP_MIN)) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_len   (req_len),
        .req_gap   (req_gap),
        .abort     (abort),
        .w         (w),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Each entry is one future cycle: bit1 = w, bit0 = done.
    logic [1:0] sched[$];
    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit chk      = 1'b0;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_gap(input int n);
        for (int i = 0; i < n; i++) sched.push_back((i == n - 1) ? 2'b01 : 2'b00);
    endtask

    task automatic step(input logic v, input int len, input int gap, input logic ab, input logic rst);
        logic exp_w, exp_done, exp_busy, exp_ready, acc;
        int   g;
        req_valid = v;
        req_len   = CNT_W'(len);
        req_gap   = CNT_W'(gap);
        abort     = ab;
        clr       = rst;
        @(negedge clk);
        exp_w     = (sched.size() != 0) ? sched[0][1] : 1'b0;
        exp_done  = (sched.size() != 0) ? sched[0][0] : 1'b0;
        exp_busy  = (sched.size() != 0);
        exp_ready = (sched.size() <= 1) && !ab;
        if (chk) begin
            check("w", w, exp_w);
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("req_ready", req_ready, exp_ready);
        end
        acc = v && exp_ready && !rst;
        if (sched.size() != 0) void'(sched.pop_front());
        if (rst) begin
            sched.delete();
        end else if (ab && exp_w) begin
            sched.delete();
            push_gap(GAP_MIN);
        end else if (acc) begin
            for (int i = 0; i < len; i++) sched.push_back(2'b10);
            g = (gap < GAP_MIN) ? GAP_MIN : gap;
            push_gap(g);
            $display("cycle %0d: accept len=%0d gap=%0d", cyc, len, gap);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        req_valid = 1'b0;
        req_len   = '0;
        req_gap   = '0;
        abort     = 1'b0;
        clr       = 1'b1;

        // Reset for two cycles; checking starts on the second.
        step(1'b0, 0, 0, 1'b0, 1'b1);
        chk = 1'b1;
        step(1'b0, 0, 0, 1'b0, 1'b1);
        idle(2);

        // Single command L=3 G=2.
        step(1'b1, 3, 2, 1'b0, 1'b0);
        idle(7);

        // Back-to-back with held valid; second gap clamps to GAP_MIN.
        step(1'b1, 3, 2, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1, 0, 1'b0, 1'b0);
        idle(4);

        // Zero-length command.
        step(1'b1, 0, 3, 1'b0, 1'b0);
        idle(5);

        // Abort during a run.
        step(1'b1, 10, 5, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b1, 1'b0);
        idle(5);

        // Abort while idle with a request pending suppresses acceptance.
        step(1'b1, 2, 2, 1'b1, 1'b0);
        idle(2);

        // Reset mid-run, then a normal command.
        step(1'b1, 8, 2, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        idle(2);
        step(1'b1, 2, 1, 1'b0, 1'b0);
        idle(5);

        // Maximum length run.
        step(1'b1, 255, 0, 1'b0, 1'b0);
        idle(258);

        // Maximum gap after a short run.
        step(1'b1, 1, 255, 1'b0, 1'b0);
        idle(258);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 1) == 1),
                 int'($urandom_range(0, 6)),
                 int'($urandom_range(0, 4)),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 49) == 0));
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/w_seq_tx.md
Name: w_seq_tx

Overview:
- Serial run-length transmitter for the speed-controller `w` line. It is the sending end of the two-consecutive-high detector.
- Accepts commands of the form "drive w high for LEN cycles, then low for GAP cycles" over a valid/ready handshake.
- Emits a registered, glitch-free `w` suitable for driving the detector's `w` input directly.
- Enforces a minimum low gap between runs so that back-to-back runs never merge at the receiver.

Parameters:
- CNT_W, 8: width of the length and gap fields and of the internal counters.
- GAP_MIN, 1: minimum low cycles after every run. Legal range is 1 to 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  synchronous reset, active-high.
- req_valid  input  1  command present.
- req_ready  output  1  command accepted this cycle when req_valid & req_ready.
- req_len  input  CNT_W  high-run length in cycles; 0 is legal.
- req_gap  input  CNT_W  requested low cycles after the run.
- abort  input  1  truncate the current high run.
- w  output  1  serial line to the detector (registered).
- busy  output  1  high while in HIGH or GAP.
- done  output  1  one-cycle pulse in the final gap cycle of each command.

Behaviour:
- Clocking and reset: one clock, clk. Reset clr is synchronous and active-high. clr has priority over every other input.
- Reset values: state IDLE, w=0, busy=0, done=0, counters=0. req_ready is 1 in the first cycle after reset.
- FSM states:
  - IDLE: w=0, busy=0, req_ready=~abort.
  - HIGH: w=1, busy=1.
  - GAP: w=0, busy=1.
- Effective gap: G = max(req_gap, GAP_MIN), latched at acceptance. The comparison is unsigned and CNT_W wide.
- Accept in cycle T with req_len=L:
  - L>0: state becomes HIGH at T+1. w=1 in cycles T+1 to T+L. State becomes GAP at T+L+1, with w=0 in cycles T+L+1 to T+L+G.
  - L=0: state becomes GAP at T+1, with w=0 in cycles T+1 to T+G. No high cycle is produced.
- Last gap cycle (gap counter = 1): done=1, and req_ready = ~abort.
  - If a request is accepted in that cycle, the next state is HIGH (or GAP when L=0) with no IDLE bubble.
  - If no request is accepted, the next state is IDLE.
- req_ready is 0 in HIGH and in every non-final GAP cycle. req_len and req_gap are sampled only on acceptance.
- abort:
  - In HIGH: next cycle is GAP with counter = GAP_MIN, regardless of req_gap. w falls at that edge. done pulses in the last of those GAP_MIN cycles.
  - In GAP and IDLE: abort has no effect on state. It suppresses req_ready for that cycle only.
- Counters:
  - Load L or G on entry to HIGH or GAP.
  - Decrement each cycle in the state.
  - Exit at count 1.
  - Counters never wrap below 0. L = 2^CNT_W-1 yields exactly 2^CNT_W-1 high cycles.
- Reset mid-operation: clr in any state returns to IDLE next cycle with w=0. The in-flight command is discarded and done is not pulsed.
- Receiver expectation: a run of L>=2 makes the detector's z=1 for cycles T+3 to T+L+1. A run of L<=1 never raises z. With GAP_MIN>=1, consecutive runs stay distinct.

Test Plan:
1. Reset behaviour: assert clr for 2 cycles, then release → w=0, busy=0, done=0, and req_ready=1 on the first post-reset cycle.
2. Single command: accept L=3, gap=2 at cycle 0 →
   - w=1 in cycles 1-3 and w=0 in cycles 4-5.
   - done=1 and req_ready=1 only in cycle 5.
   - IDLE in cycle 6.
   - The attached detector gives z=1 in cycles 3-4.
3. Back-to-back with GAP_MIN clamp: hold req_valid with L=3, gap=2 then L=1, gap=0 →
   - Second command accepted in cycle 5.
   - w=1 in cycle 6, w=0 in cycle 7 (G clamped to 1).
   - done in cycle 7.
   - The detector's z never asserts for the L=1 run.
4. Zero length: accept L=0, gap=3 at cycle 0 → w stays 0, busy=1 in cycles 1-3, done in cycle 3, IDLE in cycle 4.
5. Abort during a run: accept L=10, gap=5 at cycle 0, assert abort in cycle 2 → w=1 in cycles 1-2, w=0 from cycle 3, GAP lasts 1 cycle (GAP_MIN), done in cycle 3.
6. Reset mid-run: accept L=8, assert clr in cycle 4 → w=0, busy=0 in cycle 5, no done pulse. A new command is accepted normally afterwards.
